// File: rtl/weight_dm_responder.sv
// Local 128-bit word store answering datamover-style S2MM (write) and MM2S (read)
// command/data/status streams, with independent write and read engines.
module weight_dm_responder #(
  parameter int AW    = 12,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_axis_s2mm_cmd_tvalid,
  output logic          s_axis_s2mm_cmd_tready,
  input  logic [71:0]   s_axis_s2mm_cmd_tdata,
  input  logic          s_axis_s2mm_tvalid,
  output logic          s_axis_s2mm_tready,
  input  logic [127:0]  s_axis_s2mm_tdata,
  input  logic [15:0]   s_axis_s2mm_tkeep,
  input  logic          s_axis_s2mm_tlast,
  output logic          m_axis_s2mm_sts_tvalid,
  input  logic          m_axis_s2mm_sts_tready,
  output logic [7:0]    m_axis_s2mm_sts_tdata,
  output logic          m_axis_s2mm_sts_tkeep,
  output logic          m_axis_s2mm_sts_tlast,
  input  logic          s_axis_mm2s_cmd_tvalid,
  output logic          s_axis_mm2s_cmd_tready,
  input  logic [71:0]   s_axis_mm2s_cmd_tdata,
  output logic          m_axis_mm2s_tvalid,
  input  logic          m_axis_mm2s_tready,
  output logic [127:0]  m_axis_mm2s_tdata,
  output logic [15:0]   m_axis_mm2s_tkeep,
  output logic          m_axis_mm2s_tlast,
  output logic          m_axis_mm2s_sts_tvalid,
  input  logic          m_axis_mm2s_sts_tready,
  output logic [7:0]    m_axis_mm2s_sts_tdata,
  output logic          m_axis_mm2s_sts_tkeep,
  output logic          m_axis_mm2s_sts_tlast,
  output logic [1:0]    dbg_s2mm_state,
  output logic [1:0]    dbg_mm2s_state
);
  // All streams: a transfer happens on a rising edge where tvalid and tready are both 1.
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_STS = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_DATA = 2'd1, R_STS = 2'd2} r_state_t;

  // Last beat index (beats-1) always fits 19 bits, even for btt = 2**23-1.
  function automatic logic [18:0] f_last(input logic [22:0] btt);
    logic [22:0] m;
    m = btt - 23'd1;
    return m[22:4];
  endfunction

  function automatic logic f_decerr(input logic [AW-1:0] st, input logic [18:0] lst);
    return (33'(st) + 33'(lst)) >= 33'(DEPTH);
  endfunction

  logic [127:0] mem [DEPTH];

  logic unused_bits;
  assign unused_bits = ^{s_axis_s2mm_cmd_tdata, s_axis_mm2s_cmd_tdata, s_axis_s2mm_tlast};

  // ---------------- S2MM ----------------
  w_state_t      w_state;
  logic [AW-1:0] w_start;
  logic [18:0]   w_last, w_idx;
  logic [3:0]    w_tag;
  logic          w_decerr, w_we;
  logic [AW-1:0] w_addr;
  logic [22:0]   wc_btt;
  logic [AW-1:0] wc_start;

  assign wc_btt   = s_axis_s2mm_cmd_tdata[22:0];
  assign wc_start = s_axis_s2mm_cmd_tdata[AW+35:36];
  assign s_axis_s2mm_cmd_tready = (w_state == W_IDLE);
  assign s_axis_s2mm_tready     = (w_state == W_DATA) && !rst;
  assign m_axis_s2mm_sts_tkeep  = 1'b1;
  assign m_axis_s2mm_sts_tlast  = 1'b1;
  assign dbg_s2mm_state         = w_state;
  assign w_addr = w_start + AW'(w_idx);
  assign w_we   = (w_state == W_DATA) && s_axis_s2mm_tvalid && !rst && !w_decerr;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_start <= '0;
      w_last <= '0;
      w_idx <= '0;
      w_tag <= '0;
      w_decerr <= 1'b0;
      m_axis_s2mm_sts_tvalid <= 1'b0;
      m_axis_s2mm_sts_tdata <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (s_axis_s2mm_cmd_tvalid) begin
          w_tag <= s_axis_s2mm_cmd_tdata[67:64];
          if (wc_btt == '0) begin
            m_axis_s2mm_sts_tdata <= {4'b0001, s_axis_s2mm_cmd_tdata[67:64]};
            m_axis_s2mm_sts_tvalid <= 1'b1;
            w_state <= W_STS;
          end else begin
            w_start <= wc_start;
            w_last <= f_last(wc_btt);
            w_idx <= '0;
            w_decerr <= f_decerr(wc_start, f_last(wc_btt));
            w_state <= W_DATA;
          end
        end
        W_DATA: if (s_axis_s2mm_tvalid) begin
          if (w_idx == w_last) begin
            m_axis_s2mm_sts_tdata <= {~w_decerr, 1'b0, w_decerr, 1'b0, w_tag};
            m_axis_s2mm_sts_tvalid <= 1'b1;
            w_state <= W_STS;
          end else begin
            w_idx <= w_idx + 19'd1;
          end
        end
        W_STS: if (m_axis_s2mm_sts_tready) begin
          m_axis_s2mm_sts_tvalid <= 1'b0;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 16; b++)
      if (w_we && s_axis_s2mm_tkeep[b]) mem[w_addr][8*b +: 8] <= s_axis_s2mm_tdata[8*b +: 8];
  end

  // ---------------- MM2S ----------------
  r_state_t      r_state;
  logic [AW-1:0] r_start;
  logic [18:0]   r_last, iss_idx;
  logic [3:0]    r_tag, r_part;
  logic          r_eof, r_decerr, iss_done;
  logic          infl, infl_fin, infl_zero, infl_tlast;
  logic [15:0]   infl_keep;
  logic [127:0]  rd_raw;
  logic [127:0]  ob_data [2];
  logic [15:0]   ob_keep [2];
  logic          ob_tlast [2];
  logic          ob_fin [2];
  logic          ob_wp, ob_rp;
  logic [1:0]    ob_cnt;
  logic          pop, issue, iss_fin;
  logic [2:0]    occ;
  logic [15:0]   iss_keep;
  logic [22:0]   rc_btt;
  logic [AW-1:0] rc_start;

  assign rc_btt   = s_axis_mm2s_cmd_tdata[22:0];
  assign rc_start = s_axis_mm2s_cmd_tdata[AW+35:36];
  assign s_axis_mm2s_cmd_tready = (r_state == R_IDLE);
  assign m_axis_mm2s_tvalid     = (ob_cnt != 2'd0);
  assign m_axis_mm2s_tdata      = ob_data[ob_rp];
  assign m_axis_mm2s_tkeep      = ob_keep[ob_rp];
  assign m_axis_mm2s_tlast      = ob_tlast[ob_rp];
  assign m_axis_mm2s_sts_tkeep  = 1'b1;
  assign m_axis_mm2s_sts_tlast  = 1'b1;
  assign dbg_mm2s_state         = r_state;

  // Counting the beat leaving this cycle lets a read issue every cycle at full rate.
  assign pop      = m_axis_mm2s_tvalid && m_axis_mm2s_tready;
  assign occ      = {1'b0, ob_cnt} + {2'b00, infl} - {2'b00, pop};
  assign issue    = (r_state == R_DATA) && !iss_done && (occ < 3'd2);
  assign iss_fin  = (iss_idx == r_last);
  assign iss_keep = (iss_fin && r_part != 4'd0) ? ~(16'hffff << r_part) : 16'hffff;

  always_ff @(posedge clk) begin
    if (issue) rd_raw <= mem[r_start + AW'(iss_idx)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_start <= '0;
      r_last <= '0;
      r_tag <= '0;
      r_part <= '0;
      r_eof <= 1'b0;
      r_decerr <= 1'b0;
      iss_idx <= '0;
      iss_done <= 1'b0;
      infl <= 1'b0;
      infl_fin <= 1'b0;
      infl_zero <= 1'b0;
      infl_tlast <= 1'b0;
      infl_keep <= '0;
      for (int i = 0; i < 2; i++) begin
        ob_data[i] <= '0;
        ob_keep[i] <= '0;
        ob_tlast[i] <= 1'b0;
        ob_fin[i] <= 1'b0;
      end
      ob_wp <= 1'b0;
      ob_rp <= 1'b0;
      ob_cnt <= '0;
      m_axis_mm2s_sts_tvalid <= 1'b0;
      m_axis_mm2s_sts_tdata <= '0;
    end else begin
      infl <= issue;
      if (issue) begin
        infl_fin <= iss_fin;
        infl_zero <= r_decerr;
        infl_keep <= iss_keep;
        infl_tlast <= iss_fin && r_eof;
        if (iss_fin) iss_done <= 1'b1;
        else iss_idx <= iss_idx + 19'd1;
      end
      if (infl) begin
        ob_data[ob_wp] <= infl_zero ? '0 : rd_raw;
        ob_keep[ob_wp] <= infl_keep;
        ob_tlast[ob_wp] <= infl_tlast;
        ob_fin[ob_wp] <= infl_fin;
        ob_wp <= ~ob_wp;
      end
      if (pop) ob_rp <= ~ob_rp;
      ob_cnt <= ob_cnt + {1'b0, infl} - {1'b0, pop};
      case (r_state)
        R_IDLE: if (s_axis_mm2s_cmd_tvalid) begin
          r_tag <= s_axis_mm2s_cmd_tdata[67:64];
          r_eof <= s_axis_mm2s_cmd_tdata[30];
          r_part <= rc_btt[3:0];
          r_start <= rc_start;
          r_last <= f_last(rc_btt);
          r_decerr <= f_decerr(rc_start, f_last(rc_btt));
          iss_idx <= '0;
          iss_done <= 1'b0;
          if (rc_btt == '0) begin
            m_axis_mm2s_sts_tdata <= {4'b0001, s_axis_mm2s_cmd_tdata[67:64]};
            m_axis_mm2s_sts_tvalid <= 1'b1;
            r_state <= R_STS;
          end else begin
            r_state <= R_DATA;
          end
        end
        R_DATA: if (pop && ob_fin[ob_rp]) begin
          m_axis_mm2s_sts_tdata <= {~r_decerr, 1'b0, r_decerr, 1'b0, r_tag};
          m_axis_mm2s_sts_tvalid <= 1'b1;
          r_state <= R_STS;
        end
        R_STS: if (m_axis_mm2s_sts_tready) begin
          m_axis_mm2s_sts_tvalid <= 1'b0;
          r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_weight_dm_responder.sv
// Randomised scoreboard bench for weight_dm_responder: drivers push expected beats and
// status bytes from a reference word store; negedge monitors pop and compare on handshakes.
module tb_weight_dm_responder;
  localparam int AW = 12;
  localparam int DEPTH = 2**AW;

  logic clk = 1'b0;
  logic rst;
  logic s_axis_s2mm_cmd_tvalid, s_axis_s2mm_cmd_tready;
  logic [71:0] s_axis_s2mm_cmd_tdata;
  logic s_axis_s2mm_tvalid, s_axis_s2mm_tready, s_axis_s2mm_tlast;
  logic [127:0] s_axis_s2mm_tdata;
  logic [15:0] s_axis_s2mm_tkeep;
  logic m_axis_s2mm_sts_tvalid, m_axis_s2mm_sts_tready, m_axis_s2mm_sts_tkeep, m_axis_s2mm_sts_tlast;
  logic [7:0] m_axis_s2mm_sts_tdata;
  logic s_axis_mm2s_cmd_tvalid, s_axis_mm2s_cmd_tready;
  logic [71:0] s_axis_mm2s_cmd_tdata;
  logic m_axis_mm2s_tvalid, m_axis_mm2s_tready, m_axis_mm2s_tlast;
  logic [127:0] m_axis_mm2s_tdata;
  logic [15:0] m_axis_mm2s_tkeep;
  logic m_axis_mm2s_sts_tvalid, m_axis_mm2s_sts_tready, m_axis_mm2s_sts_tkeep, m_axis_mm2s_sts_tlast;
  logic [7:0] m_axis_mm2s_sts_tdata;
  logic [1:0] dbg_s2mm_state, dbg_mm2s_state;

  weight_dm_responder #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_s2mm_cmd_tvalid(s_axis_s2mm_cmd_tvalid), .s_axis_s2mm_cmd_tready(s_axis_s2mm_cmd_tready),
    .s_axis_s2mm_cmd_tdata(s_axis_s2mm_cmd_tdata),
    .s_axis_s2mm_tvalid(s_axis_s2mm_tvalid), .s_axis_s2mm_tready(s_axis_s2mm_tready),
    .s_axis_s2mm_tdata(s_axis_s2mm_tdata), .s_axis_s2mm_tkeep(s_axis_s2mm_tkeep),
    .s_axis_s2mm_tlast(s_axis_s2mm_tlast),
    .m_axis_s2mm_sts_tvalid(m_axis_s2mm_sts_tvalid), .m_axis_s2mm_sts_tready(m_axis_s2mm_sts_tready),
    .m_axis_s2mm_sts_tdata(m_axis_s2mm_sts_tdata), .m_axis_s2mm_sts_tkeep(m_axis_s2mm_sts_tkeep),
    .m_axis_s2mm_sts_tlast(m_axis_s2mm_sts_tlast),
    .s_axis_mm2s_cmd_tvalid(s_axis_mm2s_cmd_tvalid), .s_axis_mm2s_cmd_tready(s_axis_mm2s_cmd_tready),
    .s_axis_mm2s_cmd_tdata(s_axis_mm2s_cmd_tdata),
    .m_axis_mm2s_tvalid(m_axis_mm2s_tvalid), .m_axis_mm2s_tready(m_axis_mm2s_tready),
    .m_axis_mm2s_tdata(m_axis_mm2s_tdata), .m_axis_mm2s_tkeep(m_axis_mm2s_tkeep),
    .m_axis_mm2s_tlast(m_axis_mm2s_tlast),
    .m_axis_mm2s_sts_tvalid(m_axis_mm2s_sts_tvalid), .m_axis_mm2s_sts_tready(m_axis_mm2s_sts_tready),
    .m_axis_mm2s_sts_tdata(m_axis_mm2s_sts_tdata), .m_axis_mm2s_sts_tkeep(m_axis_mm2s_sts_tkeep),
    .m_axis_mm2s_sts_tlast(m_axis_mm2s_sts_tlast),
    .dbg_s2mm_state(dbg_s2mm_state), .dbg_mm2s_state(dbg_mm2s_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int checks = 0;
  int failures = 0;
  logic [127:0] ref_mem [DEPTH];
  logic [144:0] exp_rd_q[$];
  logic [7:0]   exp_wsts_q[$];
  logic [7:0]   exp_rsts_q[$];
  int rd_mode = 0;
  bit timing_on = 0;
  int rd_hs_cyc = 0;
  int beats_seen = 0;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: got no DUT response, expected one", nm);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Read-data tready pattern: 0 always high, 1 toggling, 2 random.
  initial begin
    m_axis_mm2s_tready = 1'b0;
    m_axis_s2mm_sts_tready = 1'b0;
    m_axis_mm2s_sts_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rd_mode)
        0: m_axis_mm2s_tready = 1'b1;
        1: m_axis_mm2s_tready = ~m_axis_mm2s_tready;
        default: m_axis_mm2s_tready = 1'($urandom_range(0, 1));
      endcase
      m_axis_s2mm_sts_tready = ($urandom_range(0, 3) != 0);
      m_axis_mm2s_sts_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitors ----------------
  initial begin
    bit prev_stall;
    logic [144:0] prev_beat, e;
    prev_stall = 0;
    prev_beat = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall)
          check("rd_stall_hold", {m_axis_mm2s_tvalid, m_axis_mm2s_tdata, m_axis_mm2s_tkeep, m_axis_mm2s_tlast},
                {1'b1, prev_beat});
        if (m_axis_mm2s_tvalid && m_axis_mm2s_tready) begin
          if (exp_rd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rd_unexpected: got beat %h, expected none", m_axis_mm2s_tdata);
          end else begin
            e = exp_rd_q.pop_front();
            check("rd_beat", {m_axis_mm2s_tdata, m_axis_mm2s_tkeep, m_axis_mm2s_tlast}, e);
            if (timing_on) check("rd_timing", cyc, rd_hs_cyc + 3 + beats_seen);
          end
          beats_seen++;
        end
        prev_stall = m_axis_mm2s_tvalid && !m_axis_mm2s_tready;
        prev_beat = {m_axis_mm2s_tdata, m_axis_mm2s_tkeep, m_axis_mm2s_tlast};
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && m_axis_s2mm_sts_tvalid && m_axis_s2mm_sts_tready) begin
      if (exp_wsts_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wsts_unexpected: got %h, expected none", m_axis_s2mm_sts_tdata);
      end else begin
        check("wsts", m_axis_s2mm_sts_tdata, exp_wsts_q.pop_front());
        check("wsts_keep_last", {m_axis_s2mm_sts_tkeep, m_axis_s2mm_sts_tlast}, 2'b11);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && m_axis_mm2s_sts_tvalid && m_axis_mm2s_sts_tready) begin
      if (exp_rsts_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsts_unexpected: got %h, expected none", m_axis_mm2s_sts_tdata);
      end else begin
        check("rsts", m_axis_mm2s_sts_tdata, exp_rsts_q.pop_front());
        check("rsts_keep_last", {m_axis_mm2s_sts_tkeep, m_axis_mm2s_sts_tlast}, 2'b11);
      end
    end
  end

  // ---------------- drivers / reference model ----------------
  function automatic logic [71:0] mk_cmd(input logic [3:0] tag, input logic [31:0] addr,
                                         input logic eof, input logic [22:0] btt);
    // Reserved, drr, dsa and type fields carry junk: the DUT must ignore them.
    return {4'($urandom), tag, addr, 1'($urandom), eof, 6'($urandom), 1'($urandom), btt};
  endfunction

  function automatic bit is_decerr(input logic [31:0] addr, input logic [22:0] btt);
    return (btt != 0) && (int'(addr[AW+3:4]) + (int'(btt) + 15) / 16 > DEPTH);
  endfunction

  task automatic send_wcmd(input logic [71:0] c);
    bit got = 0;
    int n = 0;
    s_axis_s2mm_cmd_tdata = c;
    s_axis_s2mm_cmd_tvalid = 1'b1;
    while (!got && n < 300) begin
      @(negedge clk);
      got = s_axis_s2mm_cmd_tready;
      tick;
      n++;
    end
    s_axis_s2mm_cmd_tvalid = 1'b0;
    if (!got) fail("wcmd_timeout");
  endtask

  task automatic send_rcmd(input logic [71:0] c);
    bit got = 0;
    int n = 0;
    s_axis_mm2s_cmd_tdata = c;
    s_axis_mm2s_cmd_tvalid = 1'b1;
    while (!got && n < 300) begin
      @(negedge clk);
      got = s_axis_mm2s_cmd_tready;
      if (got) rd_hs_cyc = cyc;
      tick;
      n++;
    end
    s_axis_mm2s_cmd_tvalid = 1'b0;
    if (!got) fail("rcmd_timeout");
  endtask

  task automatic do_write(input logic [3:0] tag, input logic [31:0] addr, input logic [22:0] btt,
                          input bit rand_keep, input bit gaps);
    int beats, start, n;
    bit dec, got;
    logic [127:0] d;
    logic [15:0] kk;
    beats = (int'(btt) + 15) / 16;
    start = int'(addr[AW+3:4]);
    dec = is_decerr(addr, btt);
    exp_wsts_q.push_back(btt == 0 ? {4'h1, tag} : {~dec, 1'b0, dec, 1'b0, tag});
    send_wcmd(mk_cmd(tag, addr, 1'($urandom), btt));
    for (int k = 0; k < beats; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick;
      d = {$urandom, $urandom, $urandom, $urandom};
      kk = rand_keep ? 16'($urandom) : 16'hffff;
      s_axis_s2mm_tdata = d;
      s_axis_s2mm_tkeep = kk;
      s_axis_s2mm_tlast = 1'($urandom);
      s_axis_s2mm_tvalid = 1'b1;
      got = 0;
      n = 0;
      while (!got && n < 300) begin
        @(negedge clk);
        got = s_axis_s2mm_tready;
        tick;
        n++;
      end
      s_axis_s2mm_tvalid = 1'b0;
      if (!got) begin
        fail("wbeat_timeout");
        return;
      end
      if (!dec)
        for (int b = 0; b < 16; b++)
          if (kk[b]) ref_mem[start + k][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic do_read(input logic [3:0] tag, input logic [31:0] addr, input logic eof,
                         input logic [22:0] btt);
    int beats, start;
    bit dec, fin;
    logic [127:0] d;
    logic [15:0] kk;
    logic [15:0] full = 16'hffff;
    beats = (int'(btt) + 15) / 16;
    start = int'(addr[AW+3:4]);
    dec = is_decerr(addr, btt);
    for (int k = 0; k < beats; k++) begin
      fin = (k == beats - 1);
      d = dec ? 128'd0 : ref_mem[start + k];
      kk = (fin && btt[3:0] != 0) ? full >> (16 - int'(btt[3:0])) : full;
      exp_rd_q.push_back({d, kk, fin & eof});
    end
    exp_rsts_q.push_back(btt == 0 ? {4'h1, tag} : {~dec, 1'b0, dec, 1'b0, tag});
    send_rcmd(mk_cmd(tag, addr, eof, btt));
  endtask

  task automatic wait_idle;
    int n = 0;
    while ((exp_rd_q.size() != 0 || exp_wsts_q.size() != 0 || exp_rsts_q.size() != 0) && n < 3000) begin
      tick;
      n++;
    end
    if (n >= 3000) fail("drain_timeout");
    repeat (2) tick;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit saw_sts;
    int ws, wb, rs, rb;
    rst = 1'b1;
    s_axis_s2mm_cmd_tvalid = 0; s_axis_s2mm_cmd_tdata = '0;
    s_axis_s2mm_tvalid = 0; s_axis_s2mm_tdata = '0; s_axis_s2mm_tkeep = '0; s_axis_s2mm_tlast = 0;
    s_axis_mm2s_cmd_tvalid = 0; s_axis_mm2s_cmd_tdata = '0;
    repeat (3) tick;
    @(negedge clk);
    check("rst_cmd_tready", {s_axis_s2mm_cmd_tready, s_axis_mm2s_cmd_tready}, 2'b11);
    check("rst_data_tready", s_axis_s2mm_tready, 1'b0);
    check("rst_tvalid", {m_axis_mm2s_tvalid, m_axis_s2mm_sts_tvalid, m_axis_mm2s_sts_tvalid}, 3'b000);
    check("rst_rd_out", {m_axis_mm2s_tdata, m_axis_mm2s_tkeep, m_axis_mm2s_tlast}, 145'd0);
    check("rst_sts_data", {m_axis_s2mm_sts_tdata, m_axis_mm2s_sts_tdata}, 16'h0000);
    tick;
    rst = 1'b0;
    tick;

    // Known contents for words 0..63 and the top word.
    do_write(4'h0, 32'h0, 23'd1024, 0, 0);
    do_write(4'h0, 32'((DEPTH - 1) * 16), 23'd16, 0, 0);
    wait_idle;

    // Directed write then back-to-back read with cycle timing.
    do_write(4'h3, 32'h40, 23'd64, 0, 0);
    wait_idle;
    rd_mode = 0;
    repeat (2) tick;
    timing_on = 1;
    beats_seen = 0;
    do_read(4'h5, 32'h40, 1'b1, 23'd56);
    wait_idle;
    timing_on = 0;

    // Eight beats under toggling tready.
    do_write(4'hA, 32'h100, 23'd128, 1, 1);
    wait_idle;
    rd_mode = 1;
    do_read(4'hB, 32'h100, 1'b1, 23'd128);
    wait_idle;

    // Out-of-range write discards data; top word must be unchanged; out-of-range read returns zeros.
    do_write(4'h1, 32'((DEPTH - 1) * 16), 23'd32, 0, 0);
    wait_idle;
    rd_mode = 2;
    do_read(4'hC, 32'((DEPTH - 1) * 16), 1'b1, 23'd16);
    do_read(4'h4, 32'((DEPTH - 1) * 16 + 5), 1'b0, 23'd20);
    wait_idle;

    // Zero-length commands, one alongside a write.
    fork
      do_write(4'h9, 32'h80, 23'd64, 1, 1);
      do_read(4'h2, 32'h200, 1'b1, 23'd0);
    join
    do_write(4'h6, 32'h0, 23'd0, 0, 0);
    wait_idle;

    // Reset in the middle of a 4-beat read.
    rd_mode = 0;
    repeat (2) tick;
    beats_seen = 0;
    do_read(4'h7, 32'h40, 1'b1, 23'd64);
    for (int n = 0; n < 50 && beats_seen < 2; n++) tick;
    if (beats_seen < 2) fail("rst_mid_read_wait");
    rst = 1'b1;
    exp_rd_q.delete();
    exp_rsts_q.delete();
    tick;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_tvalid", m_axis_mm2s_tvalid, 1'b0);
    saw_sts = 0;
    for (int n = 0; n < 12; n++) begin
      tick;
      saw_sts |= m_axis_mm2s_sts_tvalid;
    end
    check("rst_mid_no_sts", saw_sts, 1'b0);
    do_read(4'h8, 32'h40, 1'b0, 23'd64);
    wait_idle;

    // Randomised write/read rounds inside the initialised region, with some out-of-range ones.
    for (int i = 0; i < 30; i++) begin
      if (i % 7 == 3) begin
        ws = DEPTH - 1;
        wb = $urandom_range(2, 4);
      end else begin
        ws = $urandom_range(0, 60);
        wb = $urandom_range(1, (64 - ws) < 16 ? (64 - ws) : 16);
      end
      do_write(4'($urandom), 32'(ws * 16 + $urandom_range(0, 15)),
               23'((wb - 1) * 16 + $urandom_range(1, 16)), 1, 1'($urandom));
      wait_idle;
      rd_mode = $urandom_range(0, 2);
      if (i % 5 == 2) begin
        rs = DEPTH - 1;
        rb = $urandom_range(2, 5);
      end else begin
        rs = $urandom_range(0, 60);
        rb = $urandom_range(1, (64 - rs) < 16 ? (64 - rs) : 16);
      end
      do_read(4'($urandom), 32'(rs * 16 + $urandom_range(0, 15)), 1'($urandom),
              23'((rb - 1) * 16 + $urandom_range(1, 16)));
      wait_idle;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog: got no end of test, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
